// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, receiver state encoding and bit-timing helper.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  function automatic int unsigned calc_bit_ticks(input int unsigned clock_f,
                                                 input int unsigned baudrate);
    return clock_f / baudrate;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word-fall-through byte FIFO with wrap-bit pointers and registered head/flags.
// Kept generic so the transmitter can reuse it.
module uart_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_next;
  logic [PW-1:0] rd_next;
  logic          push_ok;
  logic          pop_ok;
  logic [7:0]    head_next;

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  always_comb begin
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);
    rd_next = rd_ptr + PW'(pop_ok);
    wr_next = wr_ptr + PW'(push_ok);
    if (push_ok && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) begin
      head_next = din;
    end else begin
      head_next = mem[rd_next[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      dout   <= '0;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      empty  <= (wr_next == rd_next);
      full   <= (wr_next[AW-1:0] == rd_next[AW-1:0]) && (wr_next[AW] != rd_next[AW]);
      if (push_ok || pop_ok) begin
        dout <= head_next;
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM and FWFT receive FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx #(
  parameter int unsigned CLOCK_F    = 100000000,
  parameter int unsigned BAUDRATE   = 9600,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       overrun
);

  import uart_pkg::*;

  localparam int unsigned BIT_TICKS  = calc_bit_ticks(CLOCK_F, BAUDRATE);
  localparam int unsigned HALF_TICKS = BIT_TICKS / 2;
  localparam int unsigned CNT_W      = $clog2(BIT_TICKS);
  localparam int unsigned BIT_W      = $clog2(DATA_BITS);

  logic                 sync1;
  logic                 sync2;
  logic [1:0]           settle;
  logic                 rx_prev;
  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 push;
  logic [7:0]           push_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 bit_end;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
`endif

  // rx_prev stays low until the synchronizer holds real line samples, so a line
  // already low at reset release never looks like a 1->0 edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      settle  <= 2'b00;
      rx_prev <= 1'b0;
    end else begin
      sync1   <= rx;
      sync2   <= sync1;
      settle  <= {settle[0], 1'b1};
      rx_prev <= sync2 & settle[1];
    end
  end

  assign bit_end = (cnt == CNT_W'(BIT_TICKS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      push      <= 1'b0;
      push_data <= '0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      push      <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rx_prev && !sync2) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == CNT_W'(HALF_TICKS - 1)) begin
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= (sync2 == START_BIT) ? DATA : IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt     <= '0;
            shreg   <= {sync2, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            cnt     <= '0;
            par_bit <= sync2;
            state   <= STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (sync2 != STOP_BIT) begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
            end else if (^{shreg, par_bit}) begin
              parity_err <= 1'b1;
              state      <= IDLE;
`endif
            end else begin
              push      <= 1'b1;
              push_data <= shreg;
              state     <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_IDLE: begin
          if (sync2) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pop      = rx_ready & ~fifo_empty;
  assign rx_valid = ~fifo_empty;

  // A completed byte that finds the FIFO full with no pop in the same cycle is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else begin
      overrun <= push & fifo_full & ~pop;
    end
  end

  uart_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .din  (push_data),
    .pop  (pop),
    .dout (data_out),
    .full (fifo_full),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 1 MHz / 100 kbaud (10 clocks per bit), FIFO depth 2.
// Frames start one clock after a posedge; the stop sample lands 98 clocks later.
module tb_uart_rx;

  localparam int unsigned BT = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [6];

  uart_rx #(
    .CLOCK_F   (1000000),
    .BAUDRATE  (100000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .data_out (data_out),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    tick(BT);
  endtask

  // Leaves the stop level on the line; the stop sample is 8 clocks later.
  task automatic send_to_stop(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    rx = stop;
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  task automatic expect_byte(input string name, input logic [7:0] d);
    send_to_stop(d, 1'b1);
    tick(9);
    check({name, "_valid"}, rx_valid, 1);
    check({name, "_data"}, data_out, d);
    rx = 1'b1;
    tick(12);
    pop_one();
    check({name, "_empty"}, rx_valid, 0);
  endtask

  initial begin
    int n0;
    vecs[0] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b0};
    vecs[1] = '{8'hA3, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'h0F, 1'b1, 1'b1, 8'h0F, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0};

    reset = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b0;
    tick(3);
    check("rst_valid", rx_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    reset = 1'b0;
    tick(5);

    // Single frames: error pulse at the stop sample, byte visible one clock later.
    for (int i = 0; i < 6; i++) begin
      send_to_stop(vecs[i].data, vecs[i].stop);
      tick(8);
      check($sformatf("v%0d_ferr_sample", i), frame_err, vecs[i].exp_ferr);
      check($sformatf("v%0d_valid_sample", i), rx_valid, 0);
      tick(1);
      check($sformatf("v%0d_valid", i), rx_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check($sformatf("v%0d_data", i), data_out, vecs[i].exp_data);
      check($sformatf("v%0d_ferr_after", i), frame_err, 0);
      check($sformatf("v%0d_ovr", i), overrun, 0);
      rx = 1'b1;
      tick(12);
      pop_one();
      check($sformatf("v%0d_empty", i), rx_valid, 0);
    end
    check("ferr_total", ferr_cnt, 1);

    // Short low glitch on an idle line.
    n0 = ferr_cnt;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(20);
    check("glitch_valid", rx_valid, 0);
    check("glitch_ferr", ferr_cnt - n0, 0);
    check("glitch_state", 32'(dut.state), 32'(uart_pkg::IDLE));
    expect_byte("post_glitch", 8'h69);

    // Break: a held-low line reports exactly one framing error.
    n0 = ferr_cnt;
    send_to_stop(8'h00, 1'b0);
    tick(80);
    check("break_ferr_once", ferr_cnt - n0, 1);
    check("break_valid", rx_valid, 0);
    rx = 1'b1;
    tick(15);
    expect_byte("post_break", 8'h0F);

    // Overrun: third byte into a full two-entry FIFO is dropped.
    send_to_stop(8'h01, 1'b1); rx = 1'b1; tick(20);
    send_to_stop(8'h02, 1'b1); rx = 1'b1; tick(20);
    send_to_stop(8'h03, 1'b1);
    tick(9);
    check("ovr_pulse", overrun, 1);
    check("ovr_head", data_out, 8'h01);
    tick(1);
    check("ovr_pulse_end", overrun, 0);
    rx = 1'b1;
    tick(10);
    pop_one();
    check("ovr_pop1", data_out, 8'h02);
    check("ovr_pop1_valid", rx_valid, 1);
    pop_one();
    check("ovr_empty", rx_valid, 0);

    // Full FIFO, pop lands on the push cycle of the third byte.
    send_to_stop(8'h01, 1'b1); rx = 1'b1; tick(20);
    send_to_stop(8'h02, 1'b1); rx = 1'b1; tick(20);
    send_to_stop(8'h03, 1'b1);
    tick(8);
    check("same_head", data_out, 8'h01);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("same_no_ovr", overrun, 0);
    check("same_read2", data_out, 8'h02);
    rx = 1'b1;
    tick(10);
    pop_one();
    check("same_read3", data_out, 8'h03);
    check("same_valid3", rx_valid, 1);
    pop_one();
    check("same_empty", rx_valid, 0);

    // Reset in the middle of bit 4 with a byte waiting in the FIFO.
    send_to_stop(8'h5A, 1'b1); rx = 1'b1; tick(20);
    check("pre_rst_valid", rx_valid, 1);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'hC3 >> i));
    rx = 1'b0;
    tick(4);
    reset = 1'b1;
    tick(2);
    check("mid_rst_valid", rx_valid, 0);
    check("mid_rst_data", data_out, 0);
    check("mid_rst_ferr", frame_err, 0);
    check("mid_rst_ovr", overrun, 0);
    n0 = ferr_cnt;
    reset = 1'b0;
    tick(30);
    check("low_after_rst_valid", rx_valid, 0);
    check("low_after_rst_ferr", ferr_cnt - n0, 0);
    check("low_after_rst_state", 32'(dut.state), 32'(uart_pkg::IDLE));
    rx = 1'b1;
    tick(20);
    expect_byte("post_rst", 8'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
